// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with BYPASS, IDCODE and USER data registers.
// All state advances on rising tck; trst is a synchronous active-low reset.
module jtag_tap_ctrl #(
    parameter int                    IR_WIDTH      = 4,
    parameter logic [31:0]           IDCODE_VALUE  = 32'h1234_5093,
    parameter int                    USER_DR_WIDTH = 8,
    parameter logic [IR_WIDTH-1:0]   INSTR_IDCODE  = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]   INSTR_USER    = IR_WIDTH'(2)
) (
    input  logic                     tck,
    input  logic                     trst,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [3:0]               state_o,
    output logic [IR_WIDTH-1:0]      ir_o,
    input  logic [USER_DR_WIDTH-1:0] user_dr_i,
    output logic [USER_DR_WIDTH-1:0] user_dr_o,
    output logic                     update_dr_pulse
);

    localparam logic [3:0] TLR    = 4'd0;
    localparam logic [3:0] RTI    = 4'd1;
    localparam logic [3:0] SEL_DR = 4'd2;
    localparam logic [3:0] CAP_DR = 4'd3;
    localparam logic [3:0] SH_DR  = 4'd4;
    localparam logic [3:0] EX1_DR = 4'd5;
    localparam logic [3:0] PA_DR  = 4'd6;
    localparam logic [3:0] EX2_DR = 4'd7;
    localparam logic [3:0] UPD_DR = 4'd8;
    localparam logic [3:0] SEL_IR = 4'd9;
    localparam logic [3:0] CAP_IR = 4'd10;
    localparam logic [3:0] SH_IR  = 4'd11;
    localparam logic [3:0] EX1_IR = 4'd12;
    localparam logic [3:0] PA_IR  = 4'd13;
    localparam logic [3:0] EX2_IR = 4'd14;
    localparam logic [3:0] UPD_IR = 4'd15;

    logic [3:0]               state_q, state_d;
    logic [IR_WIDTH-1:0]      ir_q, ir_d;
    logic [IR_WIDTH-1:0]      ir_sr_q, ir_sr_d;
    logic                     bypass_q, bypass_d;
    logic [31:0]              id_sr_q, id_sr_d;
    logic [USER_DR_WIDTH-1:0] user_sr_q, user_sr_d;
    logic [USER_DR_WIDTH-1:0] user_dr_q, user_dr_d;

    logic sel_idcode, sel_user;

    // Any opcode other than IDCODE or USER falls through to BYPASS.
    assign sel_idcode = (ir_q == INSTR_IDCODE);
    assign sel_user   = (ir_q == INSTR_USER);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PA_DR;
            PA_DR:  state_d = tms ? EX2_DR : PA_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PA_IR;
            PA_IR:  state_d = tms ? EX2_IR : PA_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        ir_d      = ir_q;
        ir_sr_d   = ir_sr_q;
        bypass_d  = bypass_q;
        id_sr_d   = id_sr_q;
        user_sr_d = user_sr_q;
        user_dr_d = user_dr_q;

        if (state_q == UPD_IR) begin
            ir_d = ir_sr_q;
        end else if (state_d == TLR) begin
            ir_d = INSTR_IDCODE;
        end

        case (state_q)
            CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
            SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
            CAP_DR: begin
                if (sel_idcode)    id_sr_d   = IDCODE_VALUE;
                else if (sel_user) user_sr_d = user_dr_i;
                else               bypass_d  = 1'b0;
            end
            SH_DR: begin
                if (sel_idcode)    id_sr_d   = {tdi, id_sr_q[31:1]};
                else if (sel_user) user_sr_d = {tdi, user_sr_q[USER_DR_WIDTH-1:1]};
                else               bypass_d  = tdi;
            end
            UPD_DR: begin
                if (sel_user) user_dr_d = user_sr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck) begin
        if (!trst) begin
            state_q   <= TLR;
            ir_q      <= INSTR_IDCODE;
            ir_sr_q   <= '0;
            bypass_q  <= 1'b0;
            id_sr_q   <= '0;
            user_sr_q <= '0;
            user_dr_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ir_sr_q   <= ir_sr_d;
            bypass_q  <= bypass_d;
            id_sr_q   <= id_sr_d;
            user_sr_q <= user_sr_d;
            user_dr_q <= user_dr_d;
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state_q == SH_IR) begin
            tdo = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_idcode)    tdo = id_sr_q[0];
            else if (sel_user) tdo = user_sr_q[0];
            else               tdo = bypass_q;
        end
    end

    assign tdo_en          = (state_q == SH_DR) || (state_q == SH_IR);
    assign state_o         = state_q;
    assign ir_o            = ir_q;
    assign user_dr_o       = user_dr_q;
    assign update_dr_pulse = (state_q == UPD_DR) && sel_user;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl; expected tdo bits go through a scoreboard queue.
module tb_jtag_tap_ctrl;

    logic       tck = 1'b0;
    logic       trst = 1'b0;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] state_o;
    logic [3:0] ir_o;
    logic [7:0] user_dr_i = 8'h00;
    logic [7:0] user_dr_o;
    logic       update_dr_pulse;

    int   checks = 0;
    int   errors = 0;
    logic expQ[$];

    jtag_tap_ctrl dut (
        .tck             (tck),
        .trst            (trst),
        .tms             (tms),
        .tdi             (tdi),
        .tdo             (tdo),
        .tdo_en          (tdo_en),
        .state_o         (state_o),
        .ir_o            (ir_o),
        .user_dr_i       (user_dr_i),
        .user_dr_o       (user_dr_o),
        .update_dr_pulse (update_dr_pulse)
    );

    always #5 tck = ~tck;

    // Inputs change 1 time unit after the rising edge, so outputs are stable when sampled.
    task automatic applyStimulus(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Must be entered in a SH_x state; the final bit also carries tms=1 to exit.
    task automatic shiftBits(input int n, input logic [31:0] din, input logic [31:0] expOut, input string tag);
        logic e;
        for (int i = 0; i < n; i++) expQ.push_back(expOut[i]);
        for (int i = 0; i < n; i++) begin
            e = expQ.pop_front();
            checkOutput($sformatf("%s_bit%0d", tag, i), {31'b0, tdo}, {31'b0, e});
            applyStimulus(i == n - 1, din[i]);
        end
    endtask

    task automatic loadIr(input logic [3:0] v);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("sh_ir_state", {28'b0, state_o}, 32'd11);
        shiftBits(4, {28'b0, v}, 32'h1, "ir_capture");
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("ir_loaded", {28'b0, ir_o}, {28'b0, v});
    endtask

    task automatic gotoShiftDr();
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(0, 0);
        applyStimulus(1, 1);
        checkOutput("rst_state", {28'b0, state_o}, 32'd0);
        checkOutput("rst_ir", {28'b0, ir_o}, 32'h1);
        checkOutput("rst_tdo_en", {31'b0, tdo_en}, 32'd0);
        checkOutput("rst_tdo", {31'b0, tdo}, 32'd0);
        checkOutput("rst_user_dr", {24'b0, user_dr_o}, 32'd0);
        trst = 1'b1;

        // IDCODE readout
        applyStimulus(0, 0);
        checkOutput("rti_state", {28'b0, state_o}, 32'd1);
        gotoShiftDr();
        checkOutput("sh_dr_state", {28'b0, state_o}, 32'd4);
        checkOutput("sh_dr_tdo_en", {31'b0, tdo_en}, 32'd1);
        shiftBits(32, 32'h0, 32'h1234_5093, "idcode");
        checkOutput("ex1_dr_state", {28'b0, state_o}, 32'd5);
        applyStimulus(1, 0);
        checkOutput("upd_dr_idcode_pulse", {31'b0, update_dr_pulse}, 32'd0);
        applyStimulus(0, 0);

        // All-ones opcode acts as BYPASS
        loadIr(4'hF);
        gotoShiftDr();
        shiftBits(4, 32'b1101, 32'b1010, "bypass_f");
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("ir_still_f", {28'b0, ir_o}, 32'hF);

        // USER capture, shift and update
        loadIr(4'h2);
        user_dr_i = 8'hA5;
        gotoShiftDr();
        shiftBits(8, 32'h3C, 32'hA5, "user");
        checkOutput("ex1_pulse_low", {31'b0, update_dr_pulse}, 32'd0);
        applyStimulus(1, 0);
        checkOutput("upd_state", {28'b0, state_o}, 32'd8);
        checkOutput("upd_pulse_high", {31'b0, update_dr_pulse}, 32'd1);
        applyStimulus(0, 0);
        checkOutput("post_upd_pulse_low", {31'b0, update_dr_pulse}, 32'd0);
        checkOutput("user_dr_o", {24'b0, user_dr_o}, 32'h3C);

        // Undefined opcode 7 as BYPASS; IR change leaves user_dr_o alone
        loadIr(4'h7);
        checkOutput("user_dr_kept", {24'b0, user_dr_o}, 32'h3C);
        gotoShiftDr();
        shiftBits(6, 32'b011001, 32'b110010, "bypass_7");
        applyStimulus(1, 0);
        checkOutput("upd_pulse_bypass", {31'b0, update_dr_pulse}, 32'd0);
        applyStimulus(0, 0);

        // Five tms=1 edges from RTI
        for (int i = 0; i < 5; i++) applyStimulus(1, 0);
        checkOutput("tlr_from_rti", {28'b0, state_o}, 32'd0);
        checkOutput("tlr_ir_idcode", {28'b0, ir_o}, 32'h1);
        checkOutput("tlr_user_kept", {24'b0, user_dr_o}, 32'h3C);

        // From SH_IR
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("at_sh_ir", {28'b0, state_o}, 32'd11);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0);
        checkOutput("tlr_from_sh_ir", {28'b0, state_o}, 32'd0);

        // From PA_DR
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("at_pa_dr", {28'b0, state_o}, 32'd6);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0);
        checkOutput("tlr_from_pa_dr", {28'b0, state_o}, 32'd0);

        // trst mid-shift in USER SH_DR
        applyStimulus(0, 0);
        loadIr(4'h2);
        gotoShiftDr();
        applyStimulus(0, 1);
        applyStimulus(0, 0);
        checkOutput("mid_shift_state", {28'b0, state_o}, 32'd4);
        trst = 1'b0;
        applyStimulus(0, 1);
        trst = 1'b1;
        checkOutput("trst_state", {28'b0, state_o}, 32'd0);
        checkOutput("trst_ir", {28'b0, ir_o}, 32'h1);
        checkOutput("trst_tdo_en", {31'b0, tdo_en}, 32'd0);
        checkOutput("trst_user_dr", {24'b0, user_dr_o}, 32'd0);
        checkOutput("trst_pulse", {31'b0, update_dr_pulse}, 32'd0);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
